// File: rtl/game_ctrl.sv
// Bomb-game supervisor: arms on start, counts strikes, drives timer/buzzer/dot, ends defused or exploded.
// Latency: every output is registered and reflects its inputs one Clk after they are sampled.
// Backpressure: none; strike and tick pulses are consumed on the cycle they arrive.
module game_ctrl #(
    parameter int N_MOD       = 4,
    parameter int MAX_STRIKES = 3,
    parameter int BUZZ_LEN    = 250
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic             tick,
    input  logic             over,
    input  logic [N_MOD-1:0] solved,
    input  logic [N_MOD-1:0] strike,
    output logic             timer_en,
    output logic             timer_rst_n,
    output logic [1:0]       strikes,
    output logic [1:0]       state,
    output logic             buzz,
    output logic             dot
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ARMED    = 2'b01,
        DEFUSED  = 2'b10,
        EXPLODED = 2'b11
    } state_t;

    // Sum must hold the current count (<=3) plus every module striking at once.
    localparam int SUMW = $clog2(N_MOD + 4) + 1;
    localparam int BW   = $clog2(BUZZ_LEN + 1);

    state_t          gstate;
    logic            start_q;
    logic [BW-1:0]   buzz_cnt;
    logic            start_edge;
    logic [SUMW-1:0] hits;
    logic [SUMW-1:0] total;
    logic [1:0]      strikes_sat;
    logic            boom;
    logic            clear;

    assign start_edge = start & ~start_q;
    assign state      = gstate;

    always_comb begin
        hits = '0;
        for (int i = 0; i < N_MOD; i++) begin
            hits = hits + SUMW'(strike[i]);
        end
        total = hits + SUMW'(strikes);
    end

    assign strikes_sat = (total >= SUMW'(MAX_STRIKES)) ? 2'(MAX_STRIKES) : total[1:0];
    assign boom        = (total >= SUMW'(MAX_STRIKES)) | over;
    assign clear       = &solved;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            gstate      <= IDLE;
            start_q     <= 1'b0;
            timer_en    <= 1'b0;
            timer_rst_n <= 1'b0;
            strikes     <= 2'b00;
            buzz        <= 1'b0;
            dot         <= 1'b0;
            buzz_cnt    <= '0;
        end else begin
            start_q  <= start;
            timer_en <= 1'b0;
            unique case (gstate)
                IDLE: begin
                    if (start_edge) begin
                        gstate      <= ARMED;
                        timer_rst_n <= 1'b1;
                        timer_en    <= tick;
                        dot         <= 1'b0;
                    end
                end
                ARMED: begin
                    strikes <= strikes_sat;
                    if (boom) begin
                        gstate   <= EXPLODED;
                        buzz     <= 1'b1;
                        dot      <= 1'b1;
                        buzz_cnt <= '0;
                    end else if (clear) begin
                        gstate   <= DEFUSED;
                        buzz     <= 1'b0;
                        dot      <= 1'b0;
                        buzz_cnt <= '0;
                    end else begin
                        // timer_en is only raised while staying armed, so a final tick is dropped.
                        timer_en <= tick;
                        if (tick) begin
                            dot <= ~dot;
                        end
                        if (|strike) begin
                            buzz_cnt <= BW'(BUZZ_LEN);
                            buzz     <= 1'b1;
                        end else if (buzz_cnt != '0) begin
                            buzz_cnt <= buzz_cnt - 1'b1;
                            buzz     <= (buzz_cnt != BW'(1));
                        end
                    end
                end
                DEFUSED, EXPLODED: begin
                    if (start_edge) begin
                        gstate      <= IDLE;
                        timer_rst_n <= 1'b0;
                        strikes     <= 2'b00;
                        buzz        <= 1'b0;
                        dot         <= 1'b0;
                        buzz_cnt    <= '0;
                    end
                end
                default: gstate <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a rule-level reference model checked every cycle.
module tb_game_ctrl;
    localparam int N_MOD       = 4;
    localparam int MAX_STRIKES = 3;
    localparam int BUZZ_LEN    = 250;

    logic             Clk;
    logic             reset;
    logic             start;
    logic             tick;
    logic             over;
    logic [N_MOD-1:0] solved;
    logic [N_MOD-1:0] strike;
    logic             timer_en;
    logic             timer_rst_n;
    logic [1:0]       strikes;
    logic [1:0]       state;
    logic             buzz;
    logic             dot;

    int checks   = 0;
    int failures = 0;

    game_ctrl #(.N_MOD(N_MOD), .MAX_STRIKES(MAX_STRIKES), .BUZZ_LEN(BUZZ_LEN)) dut (
        .Clk(Clk), .reset(reset), .start(start), .tick(tick), .over(over),
        .solved(solved), .strike(strike), .timer_en(timer_en),
        .timer_rst_n(timer_rst_n), .strikes(strikes), .state(state),
        .buzz(buzz), .dot(dot)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: game phase 0 idle, 1 armed, 2 defused, 3 exploded.
    int m_phase = 0;
    int m_strikes = 0;
    int m_buzz_left = 0;
    int m_dot = 0;
    int m_en = 0;
    int m_prev_start = 0;
    int m_hits;
    int m_total;
    int m_edge;

    always @(posedge Clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_strikes = 0; m_buzz_left = 0;
            m_dot = 0; m_en = 0; m_prev_start = 0;
        end else begin
            m_edge       = (start && (m_prev_start == 0)) ? 1 : 0;
            m_prev_start = start ? 1 : 0;
            m_hits       = $countones(strike);
            m_en         = 0;
            if (m_phase == 0) begin
                if (m_edge == 1) begin
                    m_phase = 1; m_dot = 0; m_en = tick ? 1 : 0;
                end
            end else if (m_phase == 1) begin
                m_total = m_strikes + m_hits;
                if (m_total >= MAX_STRIKES || over) begin
                    m_phase = 3;
                    m_strikes = (m_total > MAX_STRIKES) ? MAX_STRIKES : m_total;
                    m_buzz_left = 0;
                end else if (solved == '1) begin
                    m_phase = 2; m_strikes = m_total; m_buzz_left = 0;
                end else begin
                    m_strikes = m_total;
                    if (m_hits > 0) m_buzz_left = BUZZ_LEN;
                    else if (m_buzz_left > 0) m_buzz_left = m_buzz_left - 1;
                    if (tick) m_dot = 1 - m_dot;
                    m_en = tick ? 1 : 0;
                end
            end else if (m_edge == 1) begin
                m_phase = 0; m_strikes = 0; m_buzz_left = 0;
            end
        end
    end

    always @(negedge Clk) begin
        chk("cmp_state", int'(state), m_phase);
        chk("cmp_strikes", int'(strikes), m_strikes);
        chk("cmp_timer_rst_n", int'(timer_rst_n), (m_phase != 0) ? 1 : 0);
        chk("cmp_timer_en", int'(timer_en), m_en);
        chk("cmp_buzz", int'(buzz), (m_phase == 3 || (m_phase == 1 && m_buzz_left > 0)) ? 1 : 0);
        chk("cmp_dot", int'(dot), (m_phase == 3) ? 1 : ((m_phase == 1) ? m_dot : 0));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        reset = 1'b0; start = 1'b0; tick = 1'b0; over = 1'b0;
        solved = '0; strike = '0;
        cyc(3);
        chk("rst_state", int'(state), 0);
        chk("rst_timer_rst_n", int'(timer_rst_n), 0);
        chk("rst_buzz", int'(buzz), 0);
        reset = 1'b1;
        cyc(2);

        // Inputs other than start are ignored while idle.
        over = 1'b1; strike = 4'b1111; solved = 4'b1111;
        cyc(2);
        chk("idle_ignore_state", int'(state), 0);
        chk("idle_ignore_strikes", int'(strikes), 0);
        over = 1'b0; strike = '0; solved = '0;
        cyc(1);

        start = 1'b1; cyc(1); start = 1'b0;
        chk("arm_state", int'(state), 1);
        chk("arm_timer_rst_n", int'(timer_rst_n), 1);
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; cyc(1); tick = 1'b0;
            chk("tick_en_high", int'(timer_en), 1);
            chk("tick_dot", int'(dot), (i + 1) % 2);
            cyc(1);
            chk("tick_en_low", int'(timer_en), 0);
            cyc(2);
        end

        start = 1'b1; cyc(1); start = 1'b0;
        chk("armed_start_ignored", int'(state), 1);
        cyc(1);

        strike = 4'b0011; cyc(1); strike = '0;
        chk("two_strikes", int'(strikes), 2);
        hi = 1;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (buzz) hi++;
            else break;
        end
        chk("buzz_len", hi, 250);
        strike = 4'b0100; cyc(1); strike = '0;
        chk("third_strike_state", int'(state), 3);
        chk("third_strike_count", int'(strikes), 3);
        solved = 4'b1111; tick = 1'b1; cyc(2); solved = '0; tick = 1'b0;
        chk("exploded_hold_state", int'(state), 3);
        chk("exploded_buzz", int'(buzz), 1);
        chk("exploded_en", int'(timer_en), 0);

        start = 1'b1; cyc(1); start = 1'b0;
        chk("restart_state", int'(state), 0);
        chk("restart_strikes", int'(strikes), 0);
        chk("restart_timer_rst_n", int'(timer_rst_n), 0);
        cyc(1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("rearm_state", int'(state), 1);
        cyc(2);

        // Solve, time-out and a final tick together: explosion wins, no trailing enable.
        solved = 4'b1111; over = 1'b1; tick = 1'b1; cyc(1);
        solved = '0; over = 1'b0; tick = 1'b0;
        chk("boom_priority", int'(state), 3);
        chk("last_tick_no_en", int'(timer_en), 0);

        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        strike = 4'b0001; cyc(1); strike = '0;
        cyc(10);
        chk("pre_defuse_buzz", int'(buzz), 1);
        solved = 4'b1111; cyc(1); solved = '0;
        chk("defused_state", int'(state), 2);
        chk("defused_buzz", int'(buzz), 0);
        chk("defused_en", int'(timer_en), 0);
        chk("defused_strikes", int'(strikes), 1);
        strike = 4'b0001; over = 1'b1; cyc(1); strike = '0; over = 1'b0;
        chk("defused_ignore", int'(state), 2);
        chk("defused_ignore_strikes", int'(strikes), 1);

        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        strike = 4'b0001; cyc(1); strike = '0;
        chk("pre_reset_strikes", int'(strikes), 1);
        cyc(2);
        reset = 1'b0; strike = 4'b0001;
        #1;
        chk("async_reset_state", int'(state), 0);
        chk("async_reset_strikes", int'(strikes), 0);
        chk("async_reset_buzz", int'(buzz), 0);
        strike = '0; start = 1'b1;
        #2;
        reset = 1'b1;
        cyc(1);
        chk("held_start_edge", int'(state), 1);
        cyc(2);
        chk("held_start_once", int'(state), 1);
        start = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
